// File: rtl/exe_stage.sv
// Execute stage: latches the ID->EXE bus, runs the ALU or the iterative multiplier,
// issues the data-SRAM request for loads/stores and reports hazard info back to ID.
module exe_stage #(
    parameter int MUL_BITS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         id_to_exe_valid,
    output logic         exe_allow_in,
    input  logic [153:0] id_to_exe_bus,
    input  logic         mem_allow_in,
    output logic         exe_to_mem_valid,
    output logic [70:0]  exe_to_mem_bus,
    output logic [39:0]  exe_to_id_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);

    localparam int N     = 32 / MUL_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rj;
        logic [31:0] rkd;
        logic [31:0] imm;
        logic [11:0] alu_op;
        logic        src1_is_pc;
        logic        src2_is_imm;
        logic        res_from_mem;
        logic        reg_we;
        logic        mem_en;
        logic [3:0]  mem_we;
        logic [4:0]  waddr;
    } id_bus_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    id_bus_t     r;
    logic        exe_valid;
    logic        exe_ready_go;
    logic        is_mul;
    mul_state_t  state, state_nxt;
    logic        mul_start, mul_step;

    logic [31:0] mcand, mplier, acc;
    logic [CNT_W-1:0] cnt;
    logic [5:0]  sh;
    logic [MUL_BITS-1:0] chunk;
    logic [31:0] pp;

    logic [31:0] src1, src2;
    logic [31:0] add_res, sub_res, slt_res, sltu_res, and_res, nor_res, or_res;
    logic [31:0] sll_res, srl_res, sra_res, lui_res;
    logic [31:0] alu_result;
    logic        not_ready;

    // Stage valid bit: refills whenever the stage can accept, drops on reset.
    always_ff @(posedge clk) begin
        if (reset)
            exe_valid <= 1'b0;
        else if (exe_allow_in)
            exe_valid <= id_to_exe_valid;
    end

    // Instruction register: data only, loads on an accepted instruction.
    always_ff @(posedge clk) begin
        if (exe_allow_in && id_to_exe_valid)
            r <= id_bus_t'(id_to_exe_bus);
    end

    assign is_mul       = r.alu_op[7];
    assign exe_ready_go = !is_mul || (state == DONE);

    assign exe_allow_in     = !exe_valid || (exe_ready_go && mem_allow_in);
    assign exe_to_mem_valid = exe_valid && exe_ready_go;

    // Multiplier state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Multiplier next state: start on the first EXE cycle of a mul, retire on handoff.
    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        case (state)
            IDLE: begin
                if (exe_valid && is_mul) begin
                    mul_start = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mul_step = 1'b1;
                if (cnt == CNT_W'(N - 1))
                    state_nxt = DONE;
            end
            DONE: begin
                if (exe_to_mem_valid && mem_allow_in)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One MUL_BITS slice of the multiplier per BUSY cycle, shifted into place.
    assign sh    = 6'(cnt) * 6'(MUL_BITS);
    assign chunk = MUL_BITS'(mplier >> sh);
    assign pp    = mcand * 32'(chunk);

    // Multiplier datapath: operand capture and shift-add accumulation (low 32 bits only).
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (mul_start) begin
            mcand  <= src1;
            mplier <= src2;
            acc    <= '0;
            cnt    <= '0;
        end else if (mul_step) begin
            acc <= acc + (pp << sh);
            cnt <= cnt + 1'b1;
        end
    end

    assign src1 = r.src1_is_pc  ? r.pc  : r.rj;
    assign src2 = r.src2_is_imm ? r.imm : r.rkd;

    assign add_res  = src1 + src2;
    assign sub_res  = src1 - src2;
    assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
    assign sltu_res = {31'b0, src1 < src2};
    assign and_res  = src1 & src2;
    assign nor_res  = ~(src1 | src2);
    assign or_res   = src1 | src2;
    assign sll_res  = src1 << src2[4:0];
    assign srl_res  = src1 >> src2[4:0];
    assign sra_res  = 32'($signed(src1) >>> src2[4:0]);
    assign lui_res  = src2;

    // One-hot result select; the mul slot takes the accumulator.
    always_comb begin
        alu_result = ({32{r.alu_op[0]}}  & add_res)
                   | ({32{r.alu_op[1]}}  & sub_res)
                   | ({32{r.alu_op[2]}}  & slt_res)
                   | ({32{r.alu_op[3]}}  & sltu_res)
                   | ({32{r.alu_op[4]}}  & and_res)
                   | ({32{r.alu_op[5]}}  & nor_res)
                   | ({32{r.alu_op[6]}}  & or_res)
                   | ({32{r.alu_op[7]}}  & acc)
                   | ({32{r.alu_op[8]}}  & sll_res)
                   | ({32{r.alu_op[9]}}  & srl_res)
                   | ({32{r.alu_op[10]}} & sra_res)
                   | ({32{r.alu_op[11]}} & lui_res);
    end

    // Loads and unfinished muls look like load-use hazards to ID.
    assign not_ready = exe_valid && (r.res_from_mem || (is_mul && state != DONE));

    assign exe_to_mem_bus = {r.pc, r.res_from_mem, r.reg_we, r.waddr, alu_result};
    assign exe_to_id_bus  = {exe_valid, exe_valid & r.reg_we, r.waddr, alu_result, not_ready};

    // The memory request goes out only in the handoff cycle, so it fires exactly once.
    assign data_sram_en    = exe_valid && r.mem_en && exe_ready_go && mem_allow_in;
    assign data_sram_we    = data_sram_en ? r.mem_we : 4'b0;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = r.rkd;

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage.
module tb_exe_stage;

    localparam logic [11:0] OP_ADD = 12'h001, OP_SUB = 12'h002, OP_SLT = 12'h004, OP_SLTU = 12'h008;
    localparam logic [11:0] OP_AND = 12'h010, OP_NOR = 12'h020, OP_OR  = 12'h040, OP_MUL  = 12'h080;
    localparam logic [11:0] OP_SLL = 12'h100, OP_SRL = 12'h200, OP_SRA = 12'h400, OP_LUI  = 12'h800;
    localparam logic [31:0] PC0 = 32'h1C00_0100;

    logic         clk = 1'b0;
    logic         reset;
    logic         id_to_exe_valid;
    logic         exe_allow_in;
    logic [153:0] id_to_exe_bus;
    logic         mem_allow_in;
    logic         exe_to_mem_valid;
    logic [70:0]  exe_to_mem_bus;
    logic [39:0]  exe_to_id_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int n_vec = 0;
    int n_err = 0;

    exe_stage dut (
        .clk              (clk),
        .reset            (reset),
        .id_to_exe_valid  (id_to_exe_valid),
        .exe_allow_in     (exe_allow_in),
        .id_to_exe_bus    (id_to_exe_bus),
        .mem_allow_in     (mem_allow_in),
        .exe_to_mem_valid (exe_to_mem_valid),
        .exe_to_mem_bus   (exe_to_mem_bus),
        .exe_to_id_bus    (exe_to_id_bus),
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] op;
        logic [31:0] rj;
        logic [31:0] rkd;
        logic [31:0] imm;
        logic        s1pc;
        logic        s2imm;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [153:0] mk(input logic [31:0] pc, rj, rkd, imm, input logic [11:0] op,
                                        input logic s1pc, s2imm, rfm, rwe, men,
                                        input logic [3:0] mwe, input logic [4:0] wa);
        return {pc, rj, rkd, imm, op, s1pc, s2imm, rfm, rwe, men, mwe, wa};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a cycle; returns settled in its first EXE cycle.
    task automatic issue(input logic [153:0] b);
        id_to_exe_valid = 1'b1;
        id_to_exe_bus   = b;
        tick();
        id_to_exe_valid = 1'b0;
        #1;
    endtask

    // From the first EXE cycle of a mul: 5 stalled cycles, then the result cycle.
    task automatic mul_run(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_nr"},    64'(exe_to_id_bus[0]), 64'd1);
            chk({tag, "_allow"}, 64'(exe_allow_in), 64'd0);
            chk({tag, "_mv"},    64'(exe_to_mem_valid), 64'd0);
            tick();
            #1;
        end
        chk({tag, "_done_mv"},  64'(exe_to_mem_valid), 64'd1);
        chk({tag, "_res"},      64'(exe_to_mem_bus[31:0]), 64'(exp));
        chk({tag, "_done_nr"},  64'(exe_to_id_bus[0]), 64'd0);
        chk({tag, "_done_al"},  64'(exe_allow_in), 64'(mem_allow_in));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0, 32'h1};
        tbl[1]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0, 32'h0};
        tbl[2]  = '{OP_SRA,  32'h8000_0000, 32'h0,         32'h4,         1'b0, 1'b1, 32'hF800_0000};
        tbl[3]  = '{OP_SUB,  32'h0,         32'h1,         32'h0,         1'b0, 1'b0, 32'hFFFF_FFFF};
        tbl[4]  = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,         1'b0, 1'b0, 32'hF000_F000};
        tbl[5]  = '{OP_NOR,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0,         1'b0, 1'b0, 32'h0000_0F0F};
        tbl[6]  = '{OP_OR,   32'h1234_0000, 32'h0000_5678, 32'h0,         1'b0, 1'b0, 32'h1234_5678};
        tbl[7]  = '{OP_SLL,  32'h1,         32'h21,        32'h0,         1'b0, 1'b0, 32'h2};
        tbl[8]  = '{OP_SRL,  32'h8000_0000, 32'h1F,        32'h0,         1'b0, 1'b0, 32'h1};
        tbl[9]  = '{OP_LUI,  32'h0,         32'h0,         32'hABCD_E000, 1'b0, 1'b1, 32'hABCD_E000};
        tbl[10] = '{OP_ADD,  32'h0,         32'h0,         32'h4,         1'b1, 1'b1, PC0 + 32'h4};
        tbl[11] = '{OP_SRA,  32'h7000_0000, 32'h0,         32'h1C,        1'b0, 1'b1, 32'h7};

        reset = 1'b1;
        id_to_exe_valid = 1'b0;
        id_to_exe_bus = '0;
        mem_allow_in = 1'b1;
        tick();
        tick();
        chk("rst_mv",    64'(exe_to_mem_valid), 64'd0);
        chk("rst_en",    64'(data_sram_en), 64'd0);
        chk("rst_we",    64'(data_sram_we), 64'd0);
        chk("rst_idv",   64'(exe_to_id_bus[39:38]), 64'd0);
        chk("rst_nr",    64'(exe_to_id_bus[0]), 64'd0);
        chk("rst_allow", 64'(exe_allow_in), 64'd1);
        reset = 1'b0;
        tick();

        // add overflow wraps; forwarded and handed off in the entry cycle
        issue(mk(PC0, 32'h7FFF_FFFF, 32'h1, 32'h0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 5'd5));
        chk("add_mv",    64'(exe_to_mem_valid), 64'd1);
        chk("add_idbus", 64'(exe_to_id_bus), 64'({1'b1, 1'b1, 5'd5, 32'h8000_0000, 1'b0}));
        chk("add_mhdr",  64'(exe_to_mem_bus[70:32]), 64'({PC0, 1'b0, 1'b1, 5'd5}));
        chk("add_en",    64'(data_sram_en), 64'd0);
        chk("add_allow", 64'(exe_allow_in), 64'd1);
        tick();
        chk("add_drain", 64'(exe_to_mem_valid), 64'd0);

        // ALU table
        for (int i = 0; i < 12; i++) begin
            issue(mk(PC0, tbl[i].rj, tbl[i].rkd, tbl[i].imm, tbl[i].op, tbl[i].s1pc, tbl[i].s2imm,
                     1'b0, 1'b1, 1'b0, 4'h0, 5'd1));
            chk($sformatf("alu%0d_res", i), 64'(exe_to_mem_bus[31:0]), 64'(tbl[i].exp));
            chk($sformatf("alu%0d_mv", i),  64'(exe_to_mem_valid), 64'd1);
            tick();
        end

        // mul 0xFFFFFFFF*3 followed by an add waiting in ID
        id_to_exe_valid = 1'b1;
        id_to_exe_bus = mk(PC0, 32'hFFFF_FFFF, 32'h3, 32'h0, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 5'd3);
        tick();
        id_to_exe_bus = mk(32'h1C00_0010, 32'h1, 32'h2, 32'h0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 5'd4);
        #1;
        mul_run("mul1", 32'hFFFF_FFFD);
        tick();
        id_to_exe_valid = 1'b0;
        #1;
        chk("mul1_next_res", 64'(exe_to_mem_bus[31:0]), 64'd3);
        chk("mul1_next_pc",  64'(exe_to_mem_bus[70:39]), 64'h1C00_0010);
        chk("mul1_next_mv",  64'(exe_to_mem_valid), 64'd1);
        tick();

        // multi-slice mul held in DONE by MEM, then a back-to-back mul
        id_to_exe_valid = 1'b1;
        id_to_exe_bus = mk(PC0, 32'h0001_0001, 32'h0101_0101, 32'h0, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 5'd6);
        tick();
        id_to_exe_bus = mk(PC0, 32'h7, 32'h6, 32'h0, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 5'd7);
        mem_allow_in = 1'b0;
        #1;
        mul_run("mul2", 32'h0202_0101);
        tick();
        chk("mul2_hold_mv",  64'(exe_to_mem_valid), 64'd1);
        chk("mul2_hold_res", 64'(exe_to_mem_bus[31:0]), 64'h0202_0101);
        chk("mul2_hold_nr",  64'(exe_to_id_bus[0]), 64'd0);
        mem_allow_in = 1'b1;
        #1;
        chk("mul2_hand_al",  64'(exe_allow_in), 64'd1);
        tick();
        id_to_exe_valid = 1'b0;
        #1;
        mul_run("mul3", 32'd42);
        tick();

        // store held off by MEM for three cycles
        mem_allow_in = 1'b0;
        issue(mk(PC0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h24, OP_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 5'd0));
        for (int i = 0; i < 3; i++) begin
            chk("st_wait_en", 64'(data_sram_en), 64'd0);
            chk("st_wait_we", 64'(data_sram_we), 64'd0);
            chk("st_wait_al", 64'(exe_allow_in), 64'd0);
            tick();
            #1;
        end
        mem_allow_in = 1'b1;
        #1;
        chk("st_en",    64'(data_sram_en), 64'd1);
        chk("st_we",    64'(data_sram_we), 64'hF);
        chk("st_addr",  64'(data_sram_addr), 64'h0000_1024);
        chk("st_wdata", 64'(data_sram_wdata), 64'hDEAD_BEEF);
        tick();
        chk("st_after_en", 64'(data_sram_en), 64'd0);
        chk("st_after_mv", 64'(exe_to_mem_valid), 64'd0);

        // load followed by a dependent-free add, no stall
        id_to_exe_valid = 1'b1;
        id_to_exe_bus = mk(PC0, 32'h0000_2000, 32'h0, 32'h8, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 5'd8);
        tick();
        id_to_exe_bus = mk(PC0, 32'h5, 32'h6, 32'h0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 5'd9);
        #1;
        chk("ld_nr",    64'(exe_to_id_bus[0]), 64'd1);
        chk("ld_en",    64'(data_sram_en), 64'd1);
        chk("ld_we",    64'(data_sram_we), 64'd0);
        chk("ld_addr",  64'(data_sram_addr), 64'h0000_2008);
        chk("ld_rfm",   64'(exe_to_mem_bus[38]), 64'd1);
        chk("ld_allow", 64'(exe_allow_in), 64'd1);
        tick();
        id_to_exe_valid = 1'b0;
        #1;
        chk("ld_fwd_idbus", 64'(exe_to_id_bus), 64'({1'b1, 1'b1, 5'd9, 32'd11, 1'b0}));
        chk("ld_fwd_en",    64'(data_sram_en), 64'd0);
        tick();

        // reset while the multiplier is busy
        issue(mk(PC0, 32'h7, 32'h6, 32'h0, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 5'd2));
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rb_mv",    64'(exe_to_mem_valid), 64'd0);
        chk("rb_en",    64'(data_sram_en), 64'd0);
        chk("rb_idv",   64'(exe_to_id_bus[39:38]), 64'd0);
        chk("rb_nr",    64'(exe_to_id_bus[0]), 64'd0);
        chk("rb_allow", 64'(exe_allow_in), 64'd1);
        reset = 1'b0;
        tick();
        chk("rb_post_mv", 64'(exe_to_mem_valid), 64'd0);
        issue(mk(PC0, 32'h0001_0001, 32'h0101_0101, 32'h0, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 5'd2));
        mul_run("rb_mul", 32'h0202_0101);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
